// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with start/busy/done handshake and a serial difference stream
// Ports: clk, reset (sync, active-high); start, a, b in; busy, done, diff, borrow, serial_out, serial_valid out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             serial_out,
  output logic             serial_valid
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state;
  logic [WIDTH-1:0] ra, rb, rd;
  logic [CW-1:0]    cnt;
  logic             bf, d, bo;
  always_comb begin
    d  = ra[0] ^ rb[0] ^ bf;
    bo = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bf);
  end
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  assign serial_valid = state == SHIFT;
  assign serial_out   = serial_valid & d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      cnt    <= '0;
      bf     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= SHIFT;
        ra    <= a;
        rb    <= b;
        rd    <= '0;
        cnt   <= '0;
        bf    <= 1'b0;
      end
    end else if (state == SHIFT) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rd  <= {d, rd[WIDTH-1:1]};
      bf  <= bo;
      cnt <= cnt + 1'b1;
      // final slice: publish the full result so it is already valid during DONE
      if (cnt == LAST) begin
        state  <= DONE;
        diff   <= {d, rd[WIDTH-1:1]};
        borrow <= bo;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and directed checks of serial_subtractor at WIDTH=8
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] a, b, diff;
  logic       busy, done, borrow, serial_out, serial_valid;
  int         pass_cnt = 0, total_cnt = 0, cyc = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .serial_out(serial_out), .serial_valid(serial_valid)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic run_op(input vec_t v);
    a = v.a;
    b = v.b;
    start = 1'b1;
    step;
    start = 1'b0;
    a = ~v.a;
    b = ~v.b;
    for (int k = 0; k < 8; k++) begin
      chk("serial_valid", 32'(serial_valid), 32'd1);
      chk("serial_out", 32'(serial_out), 32'(v.d[k]));
      chk("done_early", 32'(done), 32'd0);
      step;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("diff", 32'(diff), 32'(v.d));
    chk("borrow", 32'(borrow), 32'(v.bo));
    chk("serial_valid_done", 32'(serial_valid), 32'd0);
    step;
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("diff_hold", 32'(diff), 32'(v.d));
    chk("serial_out_idle", 32'(serial_out), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   ndone, n, last_done;
    logic [8:0] ref9;
    vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'h01, d: 8'hFE, bo: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0};
    vecs[4] = '{a: 8'hA5, b: 8'h5A, d: 8'h4B, bo: 1'b0};
    vecs[5] = '{a: 8'h10, b: 8'h20, d: 8'hF0, bo: 1'b1};
    vecs[6] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bo: 1'b1};
    reset = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    step;
    step;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      chk("rst_sout", 32'(serial_out), 32'd0);
      chk("rst_svalid", 32'(serial_valid), 32'd0);
    end

    foreach (vecs[i]) run_op(vecs[i]);

    // start re-pulsed in cycle 4 with other operands must be ignored
    a = 8'h3C;
    b = 8'h0F;
    start = 1'b1;
    step;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) begin
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
      end else start = 1'b0;
      if (done) begin
        ndone++;
        chk("ign_done_cycle", 32'(c), 32'd9);
        chk("ign_diff", 32'(diff), 32'h2D);
        chk("ign_borrow", 32'(borrow), 32'd0);
      end
      step;
    end
    start = 1'b0;
    chk("ign_done_count", 32'(ndone), 32'd1);

    // reset in cycle 5 aborts the operation
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 1; c < 5; c++) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_svalid", 32'(serial_valid), 32'd0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      step;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    v = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0};
    run_op(v);

    // start held high: back-to-back operations every 10 cycles
    last_done = -1;
    start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      ref9 = {1'b0, a} - {1'b0, b};
      step;
      a = ~a;
      b = ~b;
      n = 1;
      while (!done && n < 12) begin
        step;
        n++;
      end
      chk("rnd_latency", 32'(n), 32'd9);
      chk("rnd_diff", 32'(diff), 32'(ref9[7:0]));
      chk("rnd_borrow", 32'(borrow), 32'(ref9[8]));
      if (last_done >= 0) chk("rnd_spacing", 32'(cyc - last_done), 32'd10);
      last_done = cyc;
      step;
    end
    start = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
